// File: rtl/sti_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sti_gen_pkg
// Description : Shared types for the serial-transmit generator: serializer
//               state encoding, serial length codes and FIFO entry header.
// Revision    : 1.0 - initial release
// ============================================================================
package sti_gen_pkg;

    // Serializer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Length codes: serial length is (code+1) quarters of the parallel word
    localparam logic [1:0] LEN_Q1   = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_Q3   = 2'b10;
    localparam logic [1:0] LEN_FULL = 2'b11;

    // FIFO entry header; the right-aligned L-bit field sits above it in the
    // stored word, giving an entry of {field, len, msb}
    typedef struct packed {
        logic [1:0] len;
        logic       msb;
    } entry_hdr_t;

endpackage : sti_gen_pkg
`default_nettype wire

// File: rtl/sti_gen_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sti_gen_fifo
// Description : Small synchronous FIFO holding pending serializer entries.
//               Caller guarantees no push when full and no pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sti_gen_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [C_AW-1:0]   r_wr_ptr;
    logic [C_AW-1:0]   r_rd_ptr;
    logic [C_AW:0]     r_count;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule : sti_gen_fifo
`default_nettype wire

// File: rtl/sti_gen.sv
`default_nettype none
// ============================================================================
// Module      : sti_gen
// Description : Parallel-to-serial transmit generator. Loads are buffered in
//               a FIFO as {field, len, msb}; a two-state serializer shifts
//               each entry out with valid/ready handshaking and chains words
//               back to back without gap cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sti_gen
    import sti_gen_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [1:0]        pi_len,
    input  logic              pi_msb,
    input  logic              pi_low,
    output logic              pi_ready,
    input  logic              so_ready,
    output logic              so_data,
    output logic              so_valid,
    output logic              busy,
    output logic              err_ovf
);

    localparam int C_QW      = DATA_W / 4;
    localparam int C_CNT_W   = $clog2(DATA_W + 1);
    localparam int C_HDR_W   = $bits(entry_hdr_t);
    localparam int C_ENTRY_W = DATA_W + C_HDR_W;
    localparam int C_CW      = $clog2(FIFO_DEPTH) + 1;

    // Serializer registers
    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [C_CNT_W-1:0]  r_cnt;
    logic                r_msb;
    logic                r_so_data;
    logic                r_so_valid;
    logic                r_err_ovf;

    // Push side
    logic                w_push;
    logic [C_CNT_W-1:0]  w_push_drop;
    logic [DATA_W-1:0]   w_push_mask;
    logic [DATA_W-1:0]   w_push_field;
    entry_hdr_t          w_push_hdr;
    logic [C_ENTRY_W-1:0] w_push_entry;

    // Pop side
    logic                w_pop;
    logic                w_empty;
    logic [C_CW-1:0]     w_count;
    logic [C_ENTRY_W-1:0] w_head_entry;
    logic [DATA_W-1:0]   w_head_field;
    entry_hdr_t          w_head_hdr;
    logic [C_CNT_W-1:0]  w_head_len;
    logic [C_CNT_W-1:0]  w_head_drop;
    logic [DATA_W-1:0]   w_head_shift;
    logic                w_head_first;

    // Shift advance
    logic [DATA_W-1:0]   w_adv_shift;
    logic                w_adv_bit;
    logic                w_last;

    // Ready comes from the registered count only, so a same-cycle pop never
    // lets a full FIFO accept
    assign pi_ready = (w_count < C_CW'(FIFO_DEPTH));
    assign w_push   = load && pi_ready;

    // Field selection: low field is masked in place, high field is shifted
    // down so every stored field is right-aligned
    assign w_push_drop  = C_CNT_W'((int'(LEN_FULL) - int'(pi_len)) * C_QW);
    assign w_push_mask  = {DATA_W{1'b1}} >> w_push_drop;
    assign w_push_field = (pi_low || (pi_len == LEN_FULL)) ? (pi_data & w_push_mask)
                                                           : (pi_data >> w_push_drop);
    assign w_push_hdr.len = pi_len;
    assign w_push_hdr.msb = pi_msb;
    assign w_push_entry   = {w_push_field, w_push_hdr};

    sti_gen_fifo #(
        .WIDTH (C_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_entry),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Head entry unpacking; MSB-first fields are left-aligned so the current
    // bit is always at one end of the shift register
    assign w_head_field = w_head_entry[C_ENTRY_W-1 -: DATA_W];
    assign w_head_hdr   = entry_hdr_t'(w_head_entry[C_HDR_W-1:0]);
    assign w_head_len   = C_CNT_W'((int'(w_head_hdr.len) + 1) * C_QW);
    assign w_head_drop  = C_CNT_W'((int'(LEN_FULL) - int'(w_head_hdr.len)) * C_QW);
    assign w_head_shift = w_head_hdr.msb ? (w_head_field << w_head_drop) : w_head_field;
    assign w_head_first = w_head_hdr.msb ? w_head_shift[DATA_W-1] : w_head_shift[0];

    assign w_adv_shift = r_msb ? (r_shift << 1) : (r_shift >> 1);
    assign w_adv_bit   = r_msb ? r_shift[DATA_W-2] : r_shift[1];
    assign w_last      = (r_cnt == C_CNT_W'(1));

    // Pop when idle, or when the last bit of the current word transfers
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || (so_ready && w_last));

    // Serializer FSM with registered serial outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_msb      <= 1'b0;
            r_so_data  <= 1'b0;
            r_so_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state    <= SHIFT;
                        r_shift    <= w_head_shift;
                        r_cnt      <= w_head_len;
                        r_msb      <= w_head_hdr.msb;
                        r_so_data  <= w_head_first;
                        r_so_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (so_ready) begin
                        if (w_last) begin
                            if (!w_empty) begin
                                r_shift   <= w_head_shift;
                                r_cnt     <= w_head_len;
                                r_msb     <= w_head_hdr.msb;
                                r_so_data <= w_head_first;
                            end else begin
                                r_state    <= IDLE;
                                r_so_data  <= 1'b0;
                                r_so_valid <= 1'b0;
                            end
                        end else begin
                            r_shift   <= w_adv_shift;
                            r_cnt     <= r_cnt - 1'b1;
                            r_so_data <= w_adv_bit;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_so_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a load offered while the FIFO is full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_ovf <= 1'b0;
        end else if (load && !pi_ready) begin
            r_err_ovf <= 1'b1;
        end
    end

    assign so_data  = r_so_data;
    assign so_valid = r_so_valid;
    assign err_ovf  = r_err_ovf;
    assign busy     = (w_count != '0) || (r_state == SHIFT);

endmodule : sti_gen
`default_nettype wire

// File: tb/tb_sti_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sti_gen
// Description : Self-checking bench for sti_gen (DATA_W=32, FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sti_gen;

    localparam int DW = 32;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] pi_data = '0;
    logic [1:0]    pi_len = 2'b00;
    logic          pi_msb = 1'b0;
    logic          pi_low = 1'b0;
    logic          so_ready = 1'b1;
    logic          pi_ready;
    logic          so_data;
    logic          so_valid;
    logic          busy;
    logic          err_ovf;

    always #5 clk = ~clk;

    sti_gen #(.DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .pi_data  (pi_data),
        .pi_len   (pi_len),
        .pi_msb   (pi_msb),
        .pi_low   (pi_low),
        .pi_ready (pi_ready),
        .so_ready (so_ready),
        .so_data  (so_data),
        .so_valid (so_valid),
        .busy     (busy),
        .err_ovf  (err_ovf)
    );

    // Reference model: queue of pending words plus the word being sent
    typedef struct {
        logic [31:0] f;
        int          L;
        bit          msb;
    } ment_t;

    ment_t mq[$];
    ment_t m_cur;
    bit    m_shift;
    int    m_idx;
    bit    m_ovf;
    bit    rec[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [1:0] c);
        return (int'(c) + 1) * 8;
    endfunction

    function automatic logic [31:0] field_of(input logic [31:0] d, input logic [1:0] c, input logic low);
        int L = len_of(c);
        logic [31:0] one = 32'h1;
        if (L == 32) return d;
        if (low) return d & ((one << L) - 32'h1);
        return d >> (32 - L);
    endfunction

    function automatic logic exp_bit();
        int pos;
        if (!m_shift) return 1'b0;
        pos = m_cur.msb ? (m_cur.L - 1 - m_idx) : m_idx;
        return m_cur.f[pos];
    endfunction

    // One clock: advance the model with the current inputs, then compare
    task automatic step();
        bit xfer, done, push, pop;
        if (so_valid && so_ready) rec.push_back(so_data);
        xfer = m_shift && so_ready;
        done = xfer && (m_idx == m_cur.L - 1);
        pop  = (!m_shift || done) && (mq.size() > 0);
        push = load && (mq.size() < FD);
        if (load && !push) m_ovf = 1'b1;
        if (xfer && !done) m_idx++;
        if (pop) begin
            m_cur   = mq.pop_front();
            m_idx   = 0;
            m_shift = 1'b1;
        end else if (done) begin
            m_shift = 1'b0;
        end
        if (push) mq.push_back('{field_of(pi_data, pi_len, pi_low), len_of(pi_len), pi_msb});
        @(posedge clk);
        #1;
        chk("so_valid", so_valid, m_shift);
        chk("so_data", so_data, exp_bit());
        chk("pi_ready", pi_ready, (mq.size() < FD));
        chk("busy", busy, (mq.size() > 0) || m_shift);
        chk("err_ovf", err_ovf, m_ovf);
    endtask

    task automatic model_clear();
        mq.delete();
        m_shift = 1'b0;
        m_idx   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst so_valid", so_valid, 0);
        chk("rst so_data", so_data, 0);
        chk("rst busy", busy, 0);
        chk("rst err_ovf", err_ovf, 0);
        chk("rst pi_ready", pi_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        load = 1'b0;
        while (busy && c < maxc) begin
            step();
            c++;
        end
        chk("drain busy", busy, 0);
    endtask

    task automatic set_in(input logic [31:0] d, input logic [1:0] len, input logic msb, input logic low);
        load   = 1'b1;
        pi_data = d;
        pi_len = len;
        pi_msb = msb;
        pi_low = low;
    endtask

    function automatic logic [31:0] packed_rec();
        logic [31:0] v = '0;
        foreach (rec[i]) v = {v[30:0], rec[i]};
        return v;
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [1:0]  len;
        logic        msb;
        logic        low;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic held;
        int   gaps;
        int   c;

        vt[0] = '{32'h000000A5, 2'b00, 1'b1, 1'b1, 32'h000000A5};
        vt[1] = '{32'hC1000000, 2'b00, 1'b0, 1'b0, 32'h00000083};
        vt[2] = '{32'h0000F0F0, 2'b01, 1'b1, 1'b1, 32'h0000F0F0};
        vt[3] = '{32'h12345678, 2'b11, 1'b1, 1'b0, 32'h12345678};
        vt[4] = '{32'h12345678, 2'b11, 1'b0, 1'b1, 32'h1E6A2C48};
        vt[5] = '{32'hABCDEF01, 2'b10, 1'b1, 1'b0, 32'h00ABCDEF};
        vt[6] = '{32'hABCDEF01, 2'b01, 1'b0, 1'b1, 32'h000080F7};

        model_clear();
        #3;
        do_reset();

        // Table-driven single words with so_ready held high
        so_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rec.delete();
            set_in(vt[i].d, vt[i].len, vt[i].msb, vt[i].low);
            step();
            chk("latency k", so_valid, 0);
            load = 1'b0;
            step();
            chk("latency k+1", so_valid, 1);
            drain(60);
            chk($sformatf("vec%0d bits", i), packed_rec(), vt[i].exp);
            chk($sformatf("vec%0d count", i), rec.size(), len_of(vt[i].len));
        end

        // Back-to-back full words filling the FIFO, then an overflowing load
        rec.delete();
        for (int i = 0; i < 5; i++) begin
            set_in(32'h11111111 * (i + 1), 2'b11, i[0], 1'b0);
            step();
        end
        chk("full pi_ready", pi_ready, 0);
        set_in(32'hDEADBEEF, 2'b11, 1'b1, 1'b0);
        step();
        chk("ovf flag", err_ovf, 1);
        load = 1'b0;
        gaps = 0;
        c = 0;
        while (busy && c < 400) begin
            if (!so_valid) gaps++;
            step();
            c++;
        end
        chk("ovf drain", busy, 0);
        chk("no gaps", gaps, 0);
        chk("ovf bits", rec.size(), 160);
        chk("ovf sticky", err_ovf, 1);

        // Backpressure at bit 5 of a 16-bit word
        rec.delete();
        set_in(32'h0000F0F0, 2'b01, 1'b1, 1'b1);
        step();
        load = 1'b0;
        step();
        repeat (5) step();
        so_ready = 1'b0;
        held = so_data;
        repeat (3) begin
            step();
            chk("stall hold", so_data, held);
            chk("stall valid", so_valid, 1);
        end
        so_ready = 1'b1;
        drain(40);
        chk("stall bits", packed_rec(), 32'h0000F0F0);
        chk("stall count", rec.size(), 16);

        // Reset mid-word with two entries queued
        set_in(32'hA5A5A5A5, 2'b11, 1'b1, 1'b0);
        step();
        set_in(32'h5A5A5A5A, 2'b11, 1'b0, 1'b0);
        step();
        set_in(32'h33333333, 2'b11, 1'b1, 1'b0);
        step();
        load = 1'b0;
        c = 0;
        while (m_idx < 10 && c < 50) begin
            step();
            c++;
        end
        chk("reach bit10", m_idx, 10);
        chk("queued 2", mq.size(), 2);
        #2;
        do_reset();
        repeat (40) step();
        chk("post-reset idle", so_valid, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            load     = ($urandom_range(0, 2) == 0);
            pi_data  = $urandom;
            pi_len   = 2'($urandom_range(0, 3));
            pi_msb   = 1'($urandom_range(0, 1));
            pi_low   = 1'($urandom_range(0, 1));
            so_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        so_ready = 1'b1;
        drain(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sti_gen
`default_nettype wire

// File: doc/sti_gen.md
STI_GEN -- requirements
Module: sti_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning parallel word width; legal values are multiples of 4, at least 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of buffered load entries; legal values are powers of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load, input, 1 bit: parallel word offered this cycle.
REQ-006 SHALL have port pi_data, input, DATA_W bits: parallel word.
REQ-007 SHALL have port pi_len, input, 2 bits: serial length L = (pi_len+1)*DATA_W/4.
REQ-008 SHALL have port pi_msb, input, 1 bit: 1 sends MSB first, 0 sends LSB first.
REQ-009 SHALL have port pi_low, input, 1 bit: 1 selects pi_data[L-1:0], 0 selects pi_data[DATA_W-1:DATA_W-L].
REQ-010 SHALL have port pi_ready, output, 1 bit: FIFO not full.
REQ-011 SHALL have port so_ready, input, 1 bit: downstream accepts the current serial bit.
REQ-012 SHALL have port so_data, output, 1 bit: serial bit.
REQ-013 SHALL have port so_valid, output, 1 bit: so_data is valid.
REQ-014 SHALL have port busy, output, 1 bit: FIFO non-empty or a word is in flight.
REQ-015 SHALL have port err_ovf, output, 1 bit: sticky flag, load attempted while pi_ready=0.

Function
REQ-016 A load SHALL be accepted on a rising edge where load=1 and pi_ready=1; the accepted entry SHALL be {selected L-bit field, L, pi_msb}.
REQ-017 pi_ready SHALL equal "FIFO count < FIFO_DEPTH", combinational from registered count; a pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-018 A load with pi_ready=0 SHALL be dropped, SHALL leave the FIFO unchanged, and SHALL set err_ovf=1 until reset.
REQ-019 FSM states SHALL be IDLE and SHIFT.
REQ-020 In IDLE with the FIFO non-empty, the next edge SHALL pop the head, load the shift register and bit counter, and enter SHIFT.
REQ-021 Latency: for a load accepted at edge k into an empty, idle block, so_valid SHALL be 1 after edge k+1.
REQ-022 so_valid SHALL be 1 exactly in SHIFT; a bit transfers on an edge where so_valid=1 and so_ready=1.
REQ-023 While so_ready=0, so_data, so_valid and the counter SHALL hold (no bit lost or repeated).
REQ-024 Exactly L transfers SHALL occur per word, in the order set by the entry's msb flag.
REQ-025 On the transfer of the last bit with the FIFO non-empty, the next entry SHALL load on the same edge; the state SHALL stay SHIFT with no gap cycle.
REQ-026 On the transfer of the last bit with the FIFO empty, the state SHALL return to IDLE and so_valid SHALL fall on that edge.
REQ-027 A push and a pop on the same edge SHALL keep the FIFO count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 If L = DATA_W, pi_low SHALL be ignored.
REQ-029 busy SHALL equal (count != 0) or (state == SHIFT).

Reset
REQ-030 When reset=0, the block SHALL immediately clear: state IDLE; FIFO pointers and count 0; so_data 0; so_valid 0; busy 0; err_ovf 0; pi_ready 1.
REQ-031 Reset asserted mid-word SHALL abort the word and purge the FIFO; no residual bits SHALL appear after release.

Structure
REQ-032 A shared package sti_gen_pkg SHALL hold the state enum (IDLE, SHIFT), the pi_len encodings (LEN_Q1..LEN_FULL) and the FIFO entry struct typedef.
REQ-033 The FIFO SHALL be a separate sub-module sti_gen_fifo, parametrised by entry width and FIFO_DEPTH; the serializer FSM SHALL reside in sti_gen.

Verification (DATA_W=32, FIFO_DEPTH=4)
REQ-034 Bench SHALL drive load 0x000000A5, pi_len=00, pi_msb=1, pi_low=1, so_ready=1 -> so_valid high 8 cycles starting after edge k+1; so_data 1,0,1,0,0,1,0,1.
REQ-035 Bench SHALL drive load 0xC1000000, pi_len=00, pi_msb=0, pi_low=0 -> so_data 1,0,0,0,0,0,1,1.
REQ-036 Bench SHALL drive 4 consecutive loads with pi_len=11 while serializing, then a 5th load on the cycle pi_ready=0 -> 5th word dropped; err_ovf=1; so_valid continuous with no gaps across words.
REQ-037 Bench SHALL drive so_ready=0 for 3 cycles at bit 5 of a 16-bit word (0xF0F0, pi_len=01, pi_low=1, pi_msb=1) -> so_data held; exactly 16 transfers, sequence 1111000011110000.
REQ-038 Bench SHALL assert reset at bit 10 of a 32-bit word with 2 entries queued -> so_valid=0 and busy=0 immediately; no so_valid after release until a new load.
